// File: rtl/spi_flash_arbiter.sv
// Two-requester arbiter for a shared byte-level SPI flash engine.
// Holds chip select for a whole multi-byte transaction and enforces setup/gap timing.
module spi_flash_arbiter #(
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  start_i,
    input  logic [15:0] wdata_i,
    output logic [1:0]  grant_o,
    output logic [7:0]  rdata_o,
    output logic [1:0]  done_o,
    output logic [1:0]  busy_o,
    output logic        eng_start_o,
    output logic [7:0]  eng_data_o,
    input  logic [7:0]  eng_data_i,
    input  logic        eng_done_i,
    input  logic        eng_busy_i,
    output logic        flash_csb_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_OWNED,
        S_DRAIN,
        S_GAP
    } state_t;

    localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
    localparam logic [3:0] GAP_LAST   = 4'(CS_GAP - 1);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_grant, w_grant_nxt;
    logic        r_last, w_last_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_inflight, w_inflight_nxt;
    logic [7:0]  r_rdata, w_rdata_nxt;
    logic [1:0]  r_done, w_done_nxt;

    logic [1:0]  w_pick;
    logic        w_owner_req;
    logic        w_owner_start;
    logic        w_accept;
    logic        w_capture;

    // r_last = 1 means requester 1 owned the bus last, so requester 0 wins a tie.
    always_comb begin
        w_pick = req_i;
        if (req_i == 2'b11) begin
            w_pick = r_last ? 2'b01 : 2'b10;
        end
    end

    assign w_owner_req   = |(req_i & r_grant);
    assign w_owner_start = |(start_i & r_grant);
    assign w_accept      = (r_state == S_OWNED) && w_owner_req && w_owner_start &&
                           !eng_busy_i && !r_inflight;
    assign w_capture     = r_inflight && eng_done_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= S_IDLE;
            r_grant    <= 2'b00;
            r_last     <= 1'b1;
            r_cnt      <= 4'd0;
            r_inflight <= 1'b0;
            r_rdata    <= 8'd0;
            r_done     <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_last     <= w_last_nxt;
            r_cnt      <= w_cnt_nxt;
            r_inflight <= w_inflight_nxt;
            r_rdata    <= w_rdata_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_last_nxt     = r_last;
        w_cnt_nxt      = r_cnt;
        w_inflight_nxt = r_inflight;
        w_rdata_nxt    = r_rdata;
        w_done_nxt     = 2'b00;

        if (w_capture) begin
            w_rdata_nxt    = eng_data_i;
            w_done_nxt     = r_grant;
            w_inflight_nxt = 1'b0;
        end
        if (w_accept) begin
            w_inflight_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (|req_i) begin
                    w_grant_nxt = w_pick;
                    w_last_nxt  = w_pick[1];
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_OWNED;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_OWNED: begin
                if (!w_owner_req) begin
                    if (r_inflight && !eng_done_i) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_grant_nxt = 2'b00;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_DRAIN: begin
                if (w_capture || !r_inflight) begin
                    w_grant_nxt = 2'b00;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                // A request waiting at gap end is granted directly, so chip select
                // stays high for exactly CS_GAP cycles between owners.
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = 4'd0;
                    if (|req_i) begin
                        w_grant_nxt = w_pick;
                        w_last_nxt  = w_pick[1];
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_grant_nxt = 2'b00;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        eng_data_o = 8'd0;
        if (r_grant[0]) begin
            eng_data_o = wdata_i[7:0];
        end else if (r_grant[1]) begin
            eng_data_o = wdata_i[15:8];
        end
    end

    assign eng_start_o = w_accept;
    assign grant_o     = r_grant;
    assign rdata_o     = r_rdata;
    assign done_o      = r_done;
    assign busy_o      = ~(r_grant & {2{(r_state == S_OWNED) && !r_inflight}});
    assign flash_csb_o = (r_state == S_IDLE) || (r_state == S_GAP);

endmodule

// File: doc/spi_flash_arbiter.md
SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

Interface
REQ-001 Parameter CS_SETUP, default 2: cycles flash_csb_o is held low after a grant before the first start is forwarded (1..15).
REQ-002 Parameter CS_GAP, default 4: cycles flash_csb_o is held high after release before any new grant (1..15).
REQ-003 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset_i  in  1  reset, asynchronous and active-low.
REQ-005 req_i  in  2  per-requester bus request; bit n held high for the whole multi-byte flash transaction (bit 0 = boot FSM, bit 1 = core flash port).
REQ-006 start_i  in  2  per-requester one-cycle byte-start pulse.
REQ-007 wdata_i  in  16  per-requester TX byte; [8n+7:8n] belongs to requester n.
REQ-008 grant_o  out  2  one-hot grant; at most one bit high.
REQ-009 rdata_o  out  8  last received byte, shared by both requesters.
REQ-010 done_o  out  2  one-cycle byte-complete pulse, to owner only.
REQ-011 busy_o  out  2  per-requester busy: high unless that requester is granted, in OWNED and no byte in flight.
REQ-012 eng_start_o  out  1  start to the byte-level SPI engine.
REQ-013 eng_data_o  out  8  TX byte to engine.
REQ-014 eng_data_i  in  8  RX byte from engine.
REQ-015 eng_done_i  in  1  engine byte-complete pulse.
REQ-016 eng_busy_i  in  1  engine busy.
REQ-017 flash_csb_o  out  1  flash chip select, active low.

Function
REQ-018 FSM states IDLE, SETUP, OWNED, DRAIN, GAP; one-hot grant register and last-owner pointer.
REQ-019 IDLE: if any req_i bit high, grant one requester and go to SETUP next cycle; flash_csb_o low from SETUP entry.
REQ-020 Arbitration round-robin: both requesting -> requester that is not the last owner wins; last-owner pointer resets to 1, so requester 0 wins the first tie.
REQ-021 SETUP: count CS_SETUP cycles, then OWNED; start_i ignored during SETUP.
REQ-022 OWNED: owner start_i with eng_busy_i low and no byte in flight -> eng_start_o pulses same cycle (combinational), eng_data_o = owner wdata_i, in-flight flag set.
REQ-023 Start from non-owner, start while in flight, or start while eng_busy_i high: dropped, no engine start, no done.
REQ-024 eng_done_i while in flight: rdata_o <= eng_data_i, done_o[owner] pulses one cycle later, in-flight flag clears.
REQ-025 eng_done_i with no byte in flight: ignored, rdata_o unchanged.
REQ-026 Owner req_i low in OWNED with no byte in flight -> GAP next cycle; with byte in flight -> DRAIN.
REQ-027 DRAIN: wait for eng_done_i, capture and pulse done_o to the (still granted) owner, then GAP.
REQ-028 GAP: grant_o cleared, flash_csb_o high, count CS_GAP cycles, then IDLE; requests during GAP wait.
REQ-029 Non-owner req_i never pre-empts the owner; ownership ends only by owner req_i deassertion.
REQ-030 Simultaneous owner req_i drop and start_i: start dropped, GAP entered.
REQ-031 eng_data_o = 0 and eng_start_o = 0 whenever no grant is active.

Reset
REQ-032 reset_i low asynchronously forces: state IDLE, grant_o 0, flash_csb_o 1, eng_start_o 0, done_o 0, busy_o 2'b11, rdata_o 0, in-flight 0, counters 0, last-owner 1.
REQ-033 Reset mid-byte: chip select releases immediately; engine done arriving after reset release is ignored.

Verification
REQ-034 req_i=2'b01, after grant send 0x03 then 0x00; engine returns 0xA5, 0x5A -> eng_data_o 0x03/0x00, rdata_o 0xA5 then 0x5A, done_o=01 twice, flash_csb_o low from SETUP to GAP.
REQ-035 req_i=2'b11 from reset -> grant 01; release -> flash_csb_o high exactly CS_GAP=4 cycles, then grant 10; next tie -> grant 01.
REQ-036 Owner 0 active, requester 1 pulses start_i with 0xFF -> no eng_start_o, done_o[1] stays 0, busy_o[1]=1.
REQ-037 Owner drops req_i one cycle after start -> DRAIN, done_o[0] pulses with byte, then GAP; no new grant until done.
REQ-038 Assert reset_i low mid-byte in OWNED -> flash_csb_o=1, grant_o=0 same cycle; stray eng_done_i after release -> no done_o.
REQ-039 Start with eng_busy_i=1 in OWNED -> dropped; retry after eng_busy_i=0 -> forwarded.
